serial_addsub_n: RTL and testbench
==================================

// Module: serial_addsub_n
// PURPOSE
//  Parametrised bit/digit-serial adder-subtractor; successor to the fixed 4-bit serial adder.
//  Latches two WIDTH-bit operands on start and processes DIGIT bits per clock, LSB first,
//  through one DIGIT-bit adder slice with a registered carry.
//  Adds subtract mode, busy/done handshake, carry/borrow-out and signed overflow.
//  Used where area matters more than latency (control-path arithmetic, bench reference units).
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be >= 2
//  DIGIT  1  bits processed per cycle; 1 <= DIGIT <= WIDTH, WIDTH % DIGIT == 0 (elaboration $error otherwise)
//  Derived: NDIG = WIDTH/DIGIT (number of digit steps)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      request; sampled only when not busy
//  sub        in   1      0: A+B, 1: A-B; sampled with start
//  operand_a  in   WIDTH  operand A; sampled with start
//  operand_b  in   WIDTH  operand B; sampled with start
//  busy       out  1      operation in progress; start ignored while high
//  done       out  1      one-cycle pulse: result/carry_out/overflow valid
//  result     out  WIDTH  A+B or A-B mod 2^WIDTH; held until the next accepted start completes
//  carry_out  out  1      add: carry out of MSB; sub: 1 = no borrow (A >= B unsigned)
//  overflow   out  1      signed two's-complement overflow of the operation
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0;
//   internal shift registers, carry and digit counter cleared.
//  FSM states: IDLE, RUN, DONE.
//   IDLE/DONE + start=1 -> RUN: latch A, B^{WIDTH{sub}}, carry=sub, cnt=0, busy=1.
//   RUN: each edge adds the low DIGIT bits of both shift regs + carry, shifts the sum
//    into result shift reg from MSB end, shifts operands right by DIGIT, cnt++.
//   RUN with cnt==NDIG-1 -> DONE: last digit; busy=0, done=1; result, carry_out, overflow updated.
//   DONE -> IDLE if start=0; DONE acts as IDLE for start (back-to-back accepted, no bubble).
//   done is high only in DONE (exactly one cycle per operation).
//  Latency: start sampled at edge 0 -> done/result valid after edge NDIG; throughput NDIG+1 cycles
//   per op (start accepted in the done cycle).
//  overflow = carry into MSB XOR carry out of MSB (taken inside the final digit slice).
//  start while busy: ignored; operands/sub are not re-sampled.
//  result/carry_out/overflow change only at the DONE transition; they are stable while busy and
//   the shift reg is internal, not wired directly to result.
//  Reset mid-RUN: operation aborted, all outputs to reset values; no done pulse.
//  DIGIT==WIDTH: single-step, NDIG=1, latency 1.
// STRUCTURE
//  Package serial_adder_pkg: typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sa_state_t.
//  Sub-module serial_digit_adder #(DIGIT): combinational a, b, cin -> sum, cout, c_msb
//   (carry into the top bit, used for overflow).
//  Counter width: $clog2(NDIG) bits, minimum 1.
// TESTING (WIDTH=8, DIGIT=1 unless stated)
//  1. 0x02 + 0x06, sub=0 -> result 0x08, carry_out 0, overflow 0; done exactly 8 cycles after start edge.
//  2. 0xFF + 0x01 -> 0x00, carry_out 1, overflow 0.  0x7F + 0x01 -> 0x80, carry_out 0, overflow 1.
//  3. sub=1: 0x05 - 0x07 -> 0xFE, carry_out 0.  0x80 - 0x01 -> 0x7F, carry_out 1, overflow 1.
//  4. start=1 with new operands while busy -> ignored, first result unchanged; start held high
//     through the done cycle -> second op accepted, done 9 cycles after the first done.
//  5. rst_n low at cycle 4 of RUN -> busy/done/result/flags 0 immediately (async), no done pulse;
//     a new op after release completes correctly.
//  6. WIDTH=16, DIGIT=4: 0x1234 + 0xEDCC -> 0x0000, carry_out 1, latency 4; random 1000-op sweep
//     against a behavioural A±B model for DIGIT in {1,2,4,16}.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sa_state_t;

  // Digit counter width; at least one bit even for a single-step configuration.
  function automatic int unsigned cnt_width(input int unsigned ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// One DIGIT-bit ripple adder slice; also exposes the carry into its top bit for overflow.
module serial_digit_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    c_msb = cin;
    for (int i = 0; i < int'(DIGIT); i++) begin
      if (i == int'(DIGIT) - 1) c_msb = carry;
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/serial_addsub_n.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock, LSB first.
module serial_addsub_n
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = cnt_width(NDIG);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_err
    $error("serial_addsub_n: illegal WIDTH/DIGIT combination");
  end

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;
  logic [WIDTH-1:0] acc_next;

  serial_digit_adder #(.DIGIT(DIGIT)) u_slice (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .c_msb (slice_cmsb)
  );

  // New digit enters the accumulator at the MSB end so the LSB digit lands at bit 0 after NDIG steps.
  assign acc_next = (acc_q >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_RUN;
          a_d     = operand_a;
          b_d     = operand_b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_next;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          result_d    = acc_next;
          carry_out_d = slice_cout;
          overflow_d  = slice_cmsb ^ slice_cout;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_addsub_n.sv
// Self-checking bench: directed 8-bit scenarios plus randomized 16-bit sweeps over several digit sizes.
module tb_serial_addsub_n;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // 8-bit, bit-serial instance
  logic       start8, sub8, busy8, done8, co8, ov8;
  logic [7:0] a8, b8, res8;

  serial_addsub_n #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8),
    .operand_a(a8), .operand_b(b8), .busy(busy8), .done(done8),
    .result(res8), .carry_out(co8), .overflow(ov8)
  );

  // 16-bit instances with DIGIT = 1, 2, 4, 16
  logic        start_v [4];
  logic        sub_v   [4];
  logic [15:0] a_v     [4];
  logic [15:0] b_v     [4];
  logic        busy_v  [4];
  logic        done_v  [4];
  logic [15:0] res_v   [4];
  logic        co_v    [4];
  logic        ov_v    [4];

  function automatic int dig_of(input int k);
    case (k)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return 16;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_w16
    localparam int unsigned D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
    serial_addsub_n #(.WIDTH(16), .DIGIT(D)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_v[g]), .sub(sub_v[g]),
      .operand_a(a_v[g]), .operand_b(b_v[g]), .busy(busy_v[g]), .done(done_v[g]),
      .result(res_v[g]), .carry_out(co_v[g]), .overflow(ov_v[g])
    );
  end

  // Reference: plain integer A+B / A-B with unsigned carry/borrow and signed range check.
  task automatic model(input int w, input logic s, input longint a, input longint b,
                       output longint r, output logic co, output logic ov);
    longint m, sa, sb, full, sfull;
    m  = longint'(1) << w;
    sa = (((a >> (w - 1)) & 1) != 0) ? a - m : a;
    sb = (((b >> (w - 1)) & 1) != 0) ? b - m : b;
    if (!s) begin
      full  = a + b;
      r     = full % m;
      co    = (full >= m);
      sfull = sa + sb;
    end else begin
      full  = a - b;
      r     = (full + m) % m;
      co    = (a >= b);
      sfull = sa - sb;
    end
    ov = (sfull >= m / 2) || (sfull < -(m / 2));
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      output logic [7:0] r, output logic co, output logic ov, output int lat);
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    r = res8; co = co8; ov = ov8;
  endtask

  task automatic run16(input int k, input logic [15:0] a, input logic [15:0] b, input logic s,
                       output logic [15:0] r, output logic co, output logic ov, output int lat);
    @(negedge clk);
    a_v[k] = a; b_v[k] = b; sub_v[k] = s; start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    lat = 0;
    while (!done_v[k] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    r = res_v[k]; co = co_v[k]; ov = ov_v[k];
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    for (int k = 0; k < 4; k++) begin
      start_v[k] = 1'b0; sub_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0;
    end
    #1;
    chk_cnt++;
    if ({busy8, done8, res8, co8, ov8} !== 12'h000)
      $display("FAIL reset_state: got busy=%b done=%b res=%h co=%b ov=%b, want all 0",
               busy8, done8, res8, co8, ov8);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({busy8, done8} !== 2'b00)
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy8, done8);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [7:0] ta [5] = '{8'h02, 8'hFF, 8'h7F, 8'h05, 8'h80};
    logic [7:0] tb_ [5] = '{8'h06, 8'h01, 8'h01, 8'h07, 8'h01};
    logic       ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0] te [5] = '{{8'h08, 2'b00}, {8'h00, 2'b10}, {8'h80, 2'b01},
                           {8'hFE, 2'b00}, {8'h7F, 2'b11}};
    logic [7:0] r;
    logic       co, ov;
    int         lat;
    for (int i = 0; i < 5; i++) begin
      run8(ta[i], tb_[i], ts[i], r, co, ov, lat);
      chk_cnt++;
      if ({r, co, ov} !== te[i])
        $display("FAIL directed_%0d: got res=%h co=%b ov=%b, want res=%h co=%b ov=%b",
                 i, r, co, ov, te[i][9:2], te[i][1], te[i][0]);
      else pass_cnt++;
      chk_cnt++;
      if (lat !== 8) $display("FAIL latency_%0d: got %0d, want 8", i, lat);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if ({done8, res8} !== {1'b0, te[i][9:2]})
        $display("FAIL done_pulse_hold_%0d: got done=%b res=%h, want done=0 res=%h",
                 i, done8, res8, te[i][9:2]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random8();
    logic [7:0] a, b, r;
    logic       s, co, ov, eco, eov;
    longint     er;
    int         lat;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      model(8, s, longint'(a), longint'(b), er, eco, eov);
      run8(a, b, s, r, co, ov, lat);
      chk_cnt++;
      if ({r, co, ov} !== {8'(er), eco, eov} || lat != 8)
        $display("FAIL random8: %h %s %h got res=%h co=%b ov=%b lat=%0d, want res=%h co=%b ov=%b lat=8",
                 a, s ? "-" : "+", b, r, co, ov, lat, 8'(er), eco, eov);
      else pass_cnt++;
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] prev;
    int         lat;
    prev = res8;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    chk_cnt++;
    if ({busy8, res8} !== {1'b1, prev})
      $display("FAIL busy_stable: got busy=%b res=%h, want busy=1 res=%h", busy8, res8, prev);
    else pass_cnt++;
    repeat (2) begin @(negedge clk); lat++; end
    a8 = 8'hAA; b8 = 8'h11; sub8 = 1'b1; start8 = 1'b1;
    repeat (2) begin @(negedge clk); lat++; end
    start8 = 1'b0;
    while (!done8 && lat < 64) begin @(negedge clk); lat++; end
    chk_cnt++;
    if ({res8, co8, ov8} !== {8'h30, 1'b0, 1'b0} || lat != 8)
      $display("FAIL busy_ignore: got res=%h co=%b ov=%b lat=%0d, want res=30 co=0 ov=0 lat=8",
               res8, co8, ov8, lat);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({busy8, done8} !== 2'b00)
      $display("FAIL busy_ignore_idle: got busy=%b done=%b, want 0 0", busy8, done8);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a8 = 8'h40; b8 = 8'h40; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h03; b8 = 8'h01; sub8 = 1'b1;
    lat = 0;
    while (!done8 && lat < 64) begin @(negedge clk); lat++; end
    chk_cnt++;
    if ({res8, co8, ov8} !== {8'h80, 1'b0, 1'b1} || lat != 8)
      $display("FAIL b2b_first: got res=%h co=%b ov=%b lat=%0d, want res=80 co=0 ov=1 lat=8",
               res8, co8, ov8, lat);
    else pass_cnt++;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 64) begin @(negedge clk); lat++; end
    chk_cnt++;
    if ({res8, co8, ov8} !== {8'h02, 1'b1, 1'b0} || lat != 9)
      $display("FAIL b2b_second: got res=%h co=%b ov=%b gap=%0d, want res=02 co=1 ov=0 gap=9",
               res8, co8, ov8, lat);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    logic       co, ov;
    int         lat, ndone;
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk_cnt++;
    if ({busy8, res8, co8} !== {1'b1, 8'h02, 1'b1})
      $display("FAIL pre_reset: got busy=%b res=%h co=%b, want busy=1 res=02 co=1", busy8, res8, co8);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({busy8, done8, res8, co8, ov8} !== 12'h000)
      $display("FAIL async_reset: got busy=%b done=%b res=%h co=%b ov=%b, want all 0",
               busy8, done8, res8, co8, ov8);
    else pass_cnt++;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) ndone++;
      if (i == 2) rst_n = 1'b1;
    end
    chk_cnt++;
    if (ndone != 0) $display("FAIL reset_no_done: got %0d done pulses, want 0", ndone);
    else pass_cnt++;
    run8(8'h33, 8'h44, 1'b1, r, co, ov, lat);
    chk_cnt++;
    if ({r, co, ov} !== {8'hEF, 1'b0, 1'b0} || lat != 8)
      $display("FAIL after_reset: got res=%h co=%b ov=%b lat=%0d, want res=ef co=0 ov=0 lat=8",
               r, co, ov, lat);
    else pass_cnt++;
  endtask

  task automatic test_digit4();
    logic [15:0] r;
    logic        co, ov;
    int          lat;
    run16(2, 16'h1234, 16'hEDCC, 1'b0, r, co, ov, lat);
    chk_cnt++;
    if ({r, co, ov} !== {16'h0000, 1'b1, 1'b0} || lat != 4)
      $display("FAIL digit4_directed: got res=%h co=%b ov=%b lat=%0d, want res=0000 co=1 ov=0 lat=4",
               r, co, ov, lat);
    else pass_cnt++;
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_sweep(input int k, input int nops);
    logic [15:0] a, b, r;
    logic        s, co, ov, eco, eov;
    longint      er;
    int          lat, elat;
    elat = 16 / dig_of(k);
    for (int i = 0; i < nops; i++) begin
      a = pick16(); b = pick16(); s = 1'($urandom);
      model(16, s, longint'(a), longint'(b), er, eco, eov);
      run16(k, a, b, s, r, co, ov, lat);
      chk_cnt++;
      if ({r, co, ov} !== {16'(er), eco, eov} || lat != elat)
        $display("FAIL sweep_d%0d: %h %s %h got res=%h co=%b ov=%b lat=%0d, want res=%h co=%b ov=%b lat=%0d",
                 dig_of(k), a, s ? "-" : "+", b, r, co, ov, lat, 16'(er), eco, eov, elat);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random8();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_digit4();
    for (int k = 0; k < 4; k++) test_sweep(k, 1000);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
